// File: rtl/pipelined_complex_mult_pkg.sv
// Shared widths and constants for the runtime-twiddle complex multiplier.
// Twiddles are signed fixed point with FRAC_W fractional bits.
package fft_cmult_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_TW_W   = 16;
  localparam int DEF_FRAC_W = 14;
  localparam int ONE_Q14    = 16384;
  localparam int STAGES     = 4;

  // Width of the final add/sub, wide enough that no step ever truncates.
  function automatic int full_w(input int data_w, input int tw_w);
    return data_w + tw_w + 3;
  endfunction
endpackage

// File: rtl/pipelined_complex_mult_if.sv
// Beat-level handshake bundle between butterfly, twiddle ROM and multiplier.
interface pipelined_complex_mult_if
  import fft_cmult_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TW_W   = DEF_TW_W
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] real_a;
  logic signed [DATA_W-1:0] imag_a;
  logic signed [TW_W-1:0]   tw_c;
  logic signed [TW_W-1:0]   tw_s;
  logic                     conj;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] real_r;
  logic signed [DATA_W-1:0] imag_r;
  logic                     ovf;
  logic                     ovf_sticky;

  modport master (
    output in_valid, real_a, imag_a, tw_c, tw_s, conj, out_ready,
    input  in_ready, out_valid, real_r, imag_r, ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, real_a, imag_a, tw_c, tw_s, conj, out_ready,
    output in_ready, out_valid, real_r, imag_r, ovf, ovf_sticky
  );
endinterface

// File: rtl/pipelined_complex_mult_round_sat.sv
// Round half toward +inf, drop FRAC_W bits, clamp to DATA_W signed range.
module cmult_round_sat
  import fft_cmult_pkg::*;
#(
  parameter int IN_W   = full_w(DEF_DATA_W, DEF_TW_W),
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic signed [IN_W-1:0]   x,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat
);
  localparam int BW = IN_W + 1;
  localparam logic signed [BW-1:0] HALF = BW'(1) <<< (FRAC_W - 1);
  localparam logic signed [BW-1:0] MAXV = (BW'(1) <<< (DATA_W - 1)) - BW'(1);
  localparam logic signed [BW-1:0] MINV = -(BW'(1) <<< (DATA_W - 1));

  logic signed [BW-1:0] biased;
  logic signed [BW-1:0] q;

  always_comb begin
    biased = BW'(x) + HALF;
    q      = biased >>> FRAC_W;
    sat    = 1'b0;
    y      = q[DATA_W-1:0];
    if (q > MAXV) begin
      y   = MAXV[DATA_W-1:0];
      sat = 1'b1;
    end else if (q < MINV) begin
      y   = MINV[DATA_W-1:0];
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/pipelined_complex_mult.sv
// 4-stage 3-multiplier complex multiply by a runtime twiddle (optionally conjugated),
// with valid/ready flow control where the whole pipe advances or holds as one.
module pipelined_complex_mult
  import fft_cmult_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TW_W   = DEF_TW_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic                          clk,
  input  logic                          rst,
  pipelined_complex_mult_if.slave       bus
);
  localparam int AW = DATA_W + 1;
  // s can reach +2^(TW_W-1) after conjugation, so s-c needs two guard bits.
  localparam int SW = TW_W + 2;
  localparam int PW = DATA_W + TW_W + 2;
  localparam int FW = full_w(DATA_W, TW_W);

  logic              advance;
  logic [STAGES:1]   vld_pipe;

  logic signed [TW_W:0]     s_in;
  logic signed [DATA_W-1:0] s1_a, s1_b;
  logic signed [TW_W-1:0]   s1_c;
  logic signed [AW-1:0]     s1_apb;
  logic signed [SW-1:0]     s1_smc, s1_cps;
  logic signed [PW-1:0]     s2_k1, s2_k2, s2_k3;
  logic signed [FW-1:0]     s3_full [2];
  logic signed [DATA_W-1:0] rs_y    [2];
  logic [1:0]               rs_sat;

  assign advance       = !bus.out_valid || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_pipe[STAGES];

  always_comb begin
    s_in = bus.conj ? -((TW_W+1)'(bus.tw_s)) : (TW_W+1)'(bus.tw_s);
  end

  // Datapath registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_a       <= bus.real_a;
      s1_b       <= bus.imag_a;
      s1_c       <= bus.tw_c;
      s1_apb     <= AW'(bus.real_a) + AW'(bus.imag_a);
      s1_smc     <= SW'(s_in) - SW'(bus.tw_c);
      s1_cps     <= SW'(bus.tw_c) + SW'(s_in);
      s2_k1      <= PW'(s1_c) * PW'(s1_apb);
      s2_k2      <= PW'(s1_a) * PW'(s1_smc);
      s2_k3      <= PW'(s1_b) * PW'(s1_cps);
      s3_full[0] <= FW'(s2_k1) - FW'(s2_k3);
      s3_full[1] <= FW'(s2_k1) + FW'(s2_k2);
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_rs
    cmult_round_sat #(
      .IN_W   (FW),
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_rs (
      .x   (s3_full[i]),
      .y   (rs_y[i]),
      .sat (rs_sat[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe       <= '0;
      bus.real_r     <= '0;
      bus.imag_r     <= '0;
      bus.ovf        <= 1'b0;
      bus.ovf_sticky <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready && bus.ovf)
        bus.ovf_sticky <= 1'b1;
      if (advance) begin
        vld_pipe   <= {vld_pipe[STAGES-1:1], bus.in_valid};
        bus.real_r <= rs_y[0];
        bus.imag_r <= rs_y[1];
        bus.ovf    <= |rs_sat;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_complex_mult.sv
// Bench for pipelined_complex_mult: scoreboard of a direct ac-bs / as+bc model
// plus per-scenario directed checks of latency, flow control and reset.
module tb_pipelined_complex_mult;
  import fft_cmult_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int TW = DEF_TW_W;
  localparam int FR = DEF_FRAC_W;

  typedef struct {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic                 ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_complex_mult_if #(.DATA_W(DW), .TW_W(TW)) bus ();

  pipelined_complex_mult #(.DATA_W(DW), .TW_W(TW), .FRAC_W(FR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb [$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;

  function automatic void clamp(input longint v, output logic signed [DW-1:0] r, output logic o);
    longint hi, lo, q;
    hi = (longint'(1) <<< (DW-1)) - 1;
    lo = -(longint'(1) <<< (DW-1));
    q  = (v + (longint'(1) <<< (FR-1))) >>> FR;
    o  = 1'b0;
    if (q > hi) begin q = hi; o = 1'b1; end
    else if (q < lo) begin q = lo; o = 1'b1; end
    r = DW'(q);
  endfunction

  function automatic exp_t model(input logic signed [DW-1:0] a, b,
                                 input logic signed [TW-1:0] c, s, input logic cj);
    exp_t   e;
    longint sv, re, im;
    logic   o1, o2;
    sv = cj ? -longint'(s) : longint'(s);
    re = longint'(a) * longint'(c) - longint'(b) * sv;
    im = longint'(a) * sv + longint'(b) * longint'(c);
    clamp(re, e.re, o1);
    clamp(im, e.im, o2);
    e.ovf = o1 | o2;
    return e;
  endfunction

  // Scoreboard: pop before push so a beat never matches itself.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.out_valid && bus.out_ready) begin
        total++; n_out++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_stale got re=%0d im=%0d with nothing outstanding", bus.real_r, bus.imag_r);
        end else begin
          mon_e = sb.pop_front();
          if ({bus.real_r, bus.imag_r, bus.ovf} !== {mon_e.re, mon_e.im, mon_e.ovf}) begin
            bad++;
            $display("FAIL sb_data got re=%0d im=%0d ovf=%0b want re=%0d im=%0d ovf=%0b",
                     bus.real_r, bus.imag_r, bus.ovf, mon_e.re, mon_e.im, mon_e.ovf);
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(bus.real_a, bus.imag_a, bus.tw_c, bus.tw_s, bus.conj));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Drive one beat into an idle pipe and wait for its result (no checks here).
  task automatic run_one(input logic signed [DW-1:0] a, b, input logic signed [TW-1:0] c, s,
                         input logic cj, output int lat, output logic signed [DW-1:0] re, im,
                         output logic o);
    bus.real_a = a; bus.imag_a = b; bus.tw_c = c; bus.tw_s = s; bus.conj = cj;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    re = bus.real_r; im = bus.imag_r; o = bus.ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.real_r !== '0) begin bad++; $display("FAIL rst_real got=%0d want=0", bus.real_r); end
    total++; if (bus.imag_r !== '0) begin bad++; $display("FAIL rst_imag got=%0d want=0", bus.imag_r); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%0b want=0", bus.ovf); end
    total++; if (bus.ovf_sticky !== 1'b0) begin bad++; $display("FAIL rst_sticky got=%0b want=0", bus.ovf_sticky); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", bus.in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic signed [DW-1:0] re, im; logic o;
    run_one(1000, -2000, 16384, 0, 1'b0, lat, re, im, o);
    total++; if (lat !== 4) begin bad++; $display("FAIL id_latency got=%0d want=4", lat); end
    total++; if (re !== 1000 || im !== -2000 || o !== 1'b0) begin bad++;
      $display("FAIL id_value got re=%0d im=%0d ovf=%0b want 1000 -2000 0", re, im, o); end
    run_one(1000, -2000, 0, 16384, 1'b0, lat, re, im, o);
    total++; if (re !== 2000 || im !== 1000) begin bad++;
      $display("FAIL mul_j got re=%0d im=%0d want 2000 1000", re, im); end
    run_one(1000, -2000, 0, 16384, 1'b1, lat, re, im, o);
    total++; if (re !== -2000 || im !== -1000) begin bad++;
      $display("FAIL mul_conj_j got re=%0d im=%0d want -2000 -1000", re, im); end
    @(posedge clk); #1;
    total++; if (bus.ovf_sticky !== 1'b0) begin bad++; $display("FAIL basic_sticky got=%0b want=0", bus.ovf_sticky); end
  endtask

  task automatic test_rounding();
    int lat; logic signed [DW-1:0] re, im; logic o;
    run_one(3, 0, 8192, 0, 1'b0, lat, re, im, o);
    total++; if (re !== 2) begin bad++; $display("FAIL round_p3 got=%0d want=2", re); end
    run_one(-3, 0, 8192, 0, 1'b0, lat, re, im, o);
    total++; if (re !== -1) begin bad++; $display("FAIL round_m3 got=%0d want=-1", re); end
    run_one(1, 0, 8192, 0, 1'b0, lat, re, im, o);
    total++; if (re !== 1) begin bad++; $display("FAIL round_p1 got=%0d want=1", re); end
  endtask

  task automatic test_saturation();
    int lat; logic signed [DW-1:0] re, im; logic o;
    run_one(32767, 32767, 16384, 16384, 1'b0, lat, re, im, o);
    total++; if (re !== 0 || im !== 32767 || o !== 1'b1) begin bad++;
      $display("FAIL sat_pos got re=%0d im=%0d ovf=%0b want 0 32767 1", re, im, o); end
    total++; if (bus.ovf_sticky !== 1'b0) begin bad++; $display("FAIL sticky_early got=%0b want=0", bus.ovf_sticky); end
    @(posedge clk); #1;
    total++; if (bus.ovf_sticky !== 1'b1) begin bad++; $display("FAIL sticky_set got=%0b want=1", bus.ovf_sticky); end
    run_one(-32768, -32768, -32768, -32768, 1'b1, lat, re, im, o);
    total++; if (re !== 32767 || im !== 0 || o !== 1'b1) begin bad++;
      $display("FAIL sat_conj_min got re=%0d im=%0d ovf=%0b want 32767 0 1", re, im, o); end
    run_one(-32768, -32768, 16384, 16384, 1'b0, lat, re, im, o);
    total++; if (re !== 0 || im !== -32768 || o !== 1'b1) begin bad++;
      $display("FAIL sat_neg got re=%0d im=%0d ovf=%0b want 0 -32768 1", re, im, o); end
    run_one(100, 100, 16384, 0, 1'b0, lat, re, im, o);
    @(posedge clk); #1;
    total++; if (bus.ovf_sticky !== 1'b1) begin bad++; $display("FAIL sticky_hold got=%0b want=1", bus.ovf_sticky); end
  endtask

  task automatic test_throughput();
    int first, last, cnt;
    first = -1; last = -1; cnt = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (cyc < 10) begin
        bus.real_a = 16'($urandom); bus.imag_a = 16'($urandom);
        bus.tw_c = 16'($urandom); bus.tw_s = 16'($urandom); bus.conj = 1'($urandom);
        bus.in_valid = 1'b1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL tp_in_ready cyc=%0d got=%0b want=1", cyc, bus.in_ready); end
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc; cnt++;
      end
      @(posedge clk); #1;
    end
    total++; if (first !== 4) begin bad++; $display("FAIL tp_first got=%0d want=4", first); end
    total++; if (cnt !== 10 || last - first !== 9) begin bad++;
      $display("FAIL tp_rate got cnt=%0d span=%0d want 10 9", cnt, last - first); end
  endtask

  task automatic test_back_to_back();
    int   sent, n0, cyc;
    logic have, acc, stall_prev;
    logic signed [DW-1:0] p_re, p_im;
    logic p_ovf;
    sent = 0; n0 = n_out; cyc = 0; have = 1'b0; stall_prev = 1'b0;
    p_re = '0; p_im = '0; p_ovf = 1'b0;
    while (n_out < n0 + 20 && cyc < 400) begin
      if (sent < 20) begin
        if (!have) begin
          bus.real_a = 16'($urandom); bus.imag_a = 16'($urandom);
          bus.tw_c = 16'($urandom); bus.tw_s = 16'($urandom); bus.conj = 1'($urandom);
          have = 1'b1;
        end
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (cyc < 6) bus.out_ready = 1'b1;
      else if (cyc < 9) bus.out_ready = 1'b0;
      else bus.out_ready = 1'($urandom);
      #1;
      total++; if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin bad++;
        $display("FAIL bp_in_ready cyc=%0d got=%0b ov=%0b or=%0b", cyc, bus.in_ready, bus.out_valid, bus.out_ready); end
      if (stall_prev) begin
        total++;
        if ({bus.out_valid, bus.real_r, bus.imag_r, bus.ovf} !== {1'b1, p_re, p_im, p_ovf}) begin bad++;
          $display("FAIL bp_stable cyc=%0d got v=%0b re=%0d im=%0d want v=1 re=%0d im=%0d",
                   cyc, bus.out_valid, bus.real_r, bus.imag_r, p_re, p_im); end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      p_re = bus.real_r; p_im = bus.imag_r; p_ovf = bus.ovf;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin sent++; have = 1'b0; end
      cyc++;
    end
    total++; if (n_out !== n0 + 20) begin bad++; $display("FAIL bp_count got=%0d want=%0d", n_out - n0, 20); end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int lat, seen; logic signed [DW-1:0] re, im; logic o;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.real_a = 16'(1000 * (i + 1)); bus.imag_a = 16'(-500 * (i + 1));
      bus.tw_c = 16384; bus.tw_s = 0; bus.conj = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.ovf_sticky !== 1'b0) begin bad++; $display("FAIL rm_sticky got=%0b want=0", bus.ovf_sticky); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rm_in_ready got=%0b want=1", bus.in_ready); end
    rst = 1'b0;
    sb.delete();
    seen = 0;
    repeat (8) begin
      if (bus.out_valid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rm_stale got=%0d cycles valid want=0", seen); end
    run_one(-1234, 4321, 16384, 0, 1'b0, lat, re, im, o);
    total++; if (lat !== 4) begin bad++; $display("FAIL rm_latency got=%0d want=4", lat); end
    total++; if (re !== -1234 || im !== 4321) begin bad++;
      $display("FAIL rm_value got re=%0d im=%0d want -1234 4321", re, im); end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.conj = 1'b0;
    bus.real_a = '0; bus.imag_a = '0; bus.tw_c = '0; bus.tw_s = '0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_throughput();
    test_back_to_back();
    test_reset_mid();
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
